// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI request arbiter.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_BUSY   = 3'd4,
    ST_SETTLE = 3'd5,
    ST_DONE   = 3'd6,
    ST_ABORT  = 3'd7
  } state_t;

  // SPI interface register bit positions
  localparam int SPI_CTRL_EN       = 0;
  localparam int SPI_CTRL_FREQ_LSB = 1;
  localparam int SPI_STAT_BUSY     = 0;

  // SCK divider select codes carried in spi_control[2:1]
  localparam logic [1:0] FREQ_SEL_0 = 2'd0;
  localparam logic [1:0] FREQ_SEL_1 = 2'd1;
  localparam logic [1:0] FREQ_SEL_2 = 2'd2;
  localparam logic [1:0] FREQ_SEL_3 = 2'd3;

  // Increment an index modulo n
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the farthest candidate back to ptr so the closest one wins last
  always_comb begin
    int            k;
    logic [IW-1:0] k_idx;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    k_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      k_idx = IW'(k);
      if (req[k_idx]) begin
        gnt        = '0;
        gnt[k_idx] = 1'b1;
        idx        = k_idx;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sharing of one SPI master register block between NUM_REQ clients.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [2*NUM_REQ-1:0]      req_freq,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata,
  output logic [DATA_W-1:0]         spi_control,
  output logic [DATA_W-1:0]         spi_tx,
  input  logic [DATA_W-1:0]         spi_status,
  input  logic [DATA_W-1:0]         spi_rx
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t              state, nxt;
  logic [IW-1:0]       ptr;
  logic [TW-1:0]       timer;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_vld;
  logic                busy, tmo;
  logic                unused_status;

  assign busy          = spi_status[SPI_STAT_BUSY];
  assign tmo           = (timer == TW'(TIMEOUT - 1));
  assign unused_status = ^spi_status[DATA_W-1:1];

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_vld)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // Next-state logic; timeout takes priority so START+BUSY never exceeds TIMEOUT
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (|req) nxt = ST_ARB;
      ST_ARB:    nxt = arb_vld ? ST_LOAD : ST_IDLE;
      ST_LOAD:   nxt = ST_START;
      ST_START:  if (tmo) nxt = ST_ABORT; else if (busy) nxt = ST_BUSY;
      ST_BUSY:   if (tmo) nxt = ST_ABORT; else if (!busy) nxt = ST_SETTLE;
      ST_SETTLE: nxt = ST_DONE;
      ST_DONE:   nxt = ST_IDLE;
      ST_ABORT:  nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Transfer watchdog: cleared while loading, counts through START and BUSY
  always_ff @(posedge clk) begin
    if (rst)                                       timer <= '0;
    else if (state == ST_LOAD)                     timer <= '0;
    else if (state == ST_START || state == ST_BUSY) timer <= timer + 1'b1;
  end

  // Round-robin pointer moves past the owner on every grant
  always_ff @(posedge clk) begin
    if (rst)                        ptr <= '0;
    else if (state == ST_ARB && arb_vld) ptr <= IW'(wrap_inc(int'(arb_idx), NUM_REQ));
  end

  // Registered outputs, driven from the state being entered so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      rdata       <= '0;
      spi_control <= '0;
      spi_tx      <= '0;
    end else begin
      if (state == ST_ARB && arb_vld) begin
        gnt                                 <= arb_gnt;
        spi_tx                              <= req_data[arb_idx*DATA_W +: DATA_W];
        spi_control[SPI_CTRL_FREQ_LSB +: 2] <= req_freq[arb_idx*2 +: 2];
      end else if (nxt == ST_IDLE) begin
        gnt <= '0;
      end
      spi_control[SPI_CTRL_EN] <= (nxt == ST_START) || (nxt == ST_BUSY);
      done <= (nxt == ST_DONE || nxt == ST_ABORT) ? gnt : '0;
      err  <= (nxt == ST_ABORT);
      if (nxt == ST_DONE) rdata <= spi_rx;
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a small behavioural SPI interface model.
module tb_spi_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic            clk, rst;
  logic [NR-1:0]   req;
  logic [2*NR-1:0] req_freq;
  logic [DW*NR-1:0] req_data;
  logic [NR-1:0]   gnt, done;
  logic            err;
  logic [DW-1:0]   rdata, spi_control, spi_tx, spi_status, spi_rx;

  int checks   = 0;
  int failures = 0;

  // model: 0 = normal 4-cycle transfer, 1 = never busy, 2 = stuck busy
  int          mode;
  logic        active, served;
  int          cnt;
  logic [31:0] rx_val;

  spi_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_freq(req_freq), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .spi_control(spi_control), .spi_tx(spi_tx),
    .spi_status(spi_status), .spi_rx(spi_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign spi_status = {31'b0, (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : active};

  // SPI interface model: busy for 4 cycles after enable, then returns rx_val
  always @(posedge clk) begin
    if (rst) begin
      active <= 1'b0; served <= 1'b0; cnt <= 0; spi_rx <= '0;
    end else begin
      if (!spi_control[0]) served <= 1'b0;
      if (active) begin
        if (cnt == 3) begin active <= 1'b0; served <= 1'b1; spi_rx <= rx_val; end
        else cnt <= cnt + 1;
      end else if (mode == 0 && spi_control[0] && !served) begin
        active <= 1'b1; cnt <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (done == '0 && cyc < budget);
    chk("done_arrived", 32'(done != '0), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"},  32'(gnt), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"},  32'(err), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_ctrl"}, spi_control, 32'd0);
    chk({tag, "_tx"},   spi_tx, 32'd0);
  endtask

  initial begin
    int cyc, n;
    logic seen;
    rst = 1'b1; req = '0; mode = 0; rx_val = '0; req_data = '0; req_freq = '0;
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single request, uncontended
    req_data[31:0] = 32'hA5A5_0001;
    req_freq[1:0]  = 2'd1;
    rx_val         = 32'h1234_5678;
    req            = 4'b0001;
    tick();                                         // now in ARB
    chk("arb_gnt", 32'(gnt), 32'd0);
    tick();                                         // LOAD
    chk("load_tx", spi_tx, 32'hA5A5_0001);
    chk("load_ctrl", spi_control, 32'h2);
    chk("load_gnt", 32'(gnt), 32'h1);
    tick();                                         // START
    chk("start_ctrl", spi_control, 32'h3);
    wait_done(100, cyc);
    chk("single_latency", 32'(cyc + 3), 32'd10);
    chk("single_done", 32'(done), 32'h1);
    chk("single_err", 32'(err), 32'd0);
    chk("single_rdata", rdata, 32'h1234_5678);
    chk("single_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    chk("single_done_clr", 32'(done), 32'd0);
    chk("single_gnt_clr", 32'(gnt), 32'd0);

    // Contention: all four held, pointer reset to 0
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_data[i*DW +: DW] = 32'hD000_0000 | 32'(i);
      req_freq[i*2 +: 2]   = 2'(i);
    end
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      rx_val = 32'hCAFE_0000 + 32'(t);
      wait_done(100, cyc);
      chk("cont_done", 32'(done), 32'(1 << (t % 4)));
      chk("cont_gnt", 32'(gnt), 32'(1 << (t % 4)));
      chk("cont_tx", spi_tx, 32'hD000_0000 | 32'(t % 4));
      chk("cont_ctrl", spi_control, 32'((t % 4) << 1));
      chk("cont_rdata", rdata, 32'hCAFE_0000 + 32'(t));
      if (t == 4) req = '0;
    end

    // Fairness: pointer is now 1; owner 2 re-requests while 3 waits
    rx_val = 32'h0000_FA12;
    req = 4'b1100;
    wait_done(100, cyc);
    chk("fair_first", 32'(done), 32'h4);
    req = 4'b1000;
    tick();
    req = 4'b1100;
    wait_done(100, cyc);
    chk("fair_second", 32'(done), 32'h8);
    req = 4'b0100;
    wait_done(100, cyc);
    chk("fair_third", 32'(done), 32'h4);
    req = '0;

    // Timeout: interface never goes busy
    mode = 1;
    req  = 4'b0001;
    n = 0;
    do begin tick(); n++; end while (!spi_control[0] && n < 20);
    chk("tmo_enable_seen", 32'(spi_control[0]), 32'd1);
    wait_done(40, cyc);
    chk("tmo_cycles", 32'(cyc), 32'd16);
    chk("tmo_done", 32'(done), 32'h1);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_rdata", rdata, 32'h0000_FA12);
    chk("tmo_enable", 32'(spi_control[0]), 32'd0);
    req = '0;
    tick();
    chk("tmo_err_clr", 32'(err), 32'd0);
    chk("tmo_done_clr", 32'(done), 32'd0);

    // Stuck busy, then recovery with a normal request
    mode = 2;
    req  = 4'b0010;
    wait_done(40, cyc);
    chk("stuck_done", 32'(done), 32'h2);
    chk("stuck_err", 32'(err), 32'd1);
    chk("stuck_enable", 32'(spi_control[0]), 32'd0);
    mode   = 0;
    rx_val = 32'h5151_0002;
    req    = 4'b0100;
    wait_done(100, cyc);
    chk("recover_done", 32'(done), 32'h4);
    chk("recover_err", 32'(err), 32'd0);
    chk("recover_rdata", rdata, 32'h5151_0002);
    req = '0;

    // Reset while BUSY
    req = 4'b0001;
    n = 0;
    do begin tick(); n++; end while (!spi_status[0] && n < 20);
    tick();
    chk("mid_busy_enable", 32'(spi_control[0]), 32'd1);
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_busy");
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (done != '0) seen = 1'b1; end
    chk("rst_no_done", 32'(seen), 32'd0);
    rx_val = 32'h7777_0003;
    req    = 4'b0001;
    wait_done(100, cyc);
    chk("post_rst_done", 32'(done), 32'h1);
    chk("post_rst_rdata", rdata, 32'h7777_0003);
    chk("post_rst_err", 32'(err), 32'd0);
    req = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
